// File: rtl/clk_meter_pkg.sv
// Shared types and defaults for the clock period meter.
// Holds the measurement state enum and the default counter width / timeout.
package clk_meter_pkg;

    localparam int DEF_CNT_W   = 32;
    localparam int DEF_TIMEOUT = 1000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        LOCKED = 2'd2
    } meter_state_e;

    // True in the states where edges produce measurements.
    function automatic logic is_measuring(input meter_state_e st);
        return (st == ARM) || (st == LOCKED);
    endfunction

endpackage

// File: rtl/clk_period_meter_if.sv
// Signal bundle between the period meter and its consumer.
// slave  : the meter (samples sig_in, drives results).
// master : the consumer (drives sig_in, reads results).
interface clk_period_meter_if
    import clk_meter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             sig_in;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    modport master (
        output sig_in,
        input  rise_pulse, fall_pulse, period, high_time,
        input  meas_valid, locked, timeout
    );

    modport slave (
        input  sig_in,
        output rise_pulse, fall_pulse, period, high_time,
        output meas_valid, locked, timeout
    );
endinterface

// File: rtl/sync_edge_det.sv
// Synchronizer plus edge detector for an asynchronous level input.
// rise_next/fall_next flag the edge one cycle before the registered
// rise_pulse/fall_pulse strobes so a consumer can update its own registers
// in the same cycle the strobe becomes visible.
// Optional macro CLK_PERIOD_METER_GLITCH_FILTER_EN: a new level is accepted
// only after the synchronized input has held it for 2 consecutive cycles.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_next,
    output logic fall_next,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_last_s;
    logic                   rise_det_s;
    logic                   fall_det_s;
    logic                   rise_pulse_r;
    logic                   fall_pulse_r;

    // Metastability synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_last_s = sync_r[SYNC_STAGES-1];

`ifdef CLK_PERIOD_METER_GLITCH_FILTER_EN
    logic qual_r;
    logic level_r;

    // qual_r is the previous synchronized sample; level_r is the accepted level,
    // which also acts as the delay flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qual_r  <= 1'b0;
            level_r <= 1'b0;
        end else begin
            qual_r <= sync_last_s;
            if (sync_last_s == qual_r) begin
                level_r <= qual_r;
            end else begin
                level_r <= level_r;
            end
        end
    end

    // An edge is accepted when two equal samples differ from the accepted level.
    always_comb begin
        rise_det_s = 1'b0;
        fall_det_s = 1'b0;
        if (sync_last_s == qual_r) begin
            rise_det_s = sync_last_s & ~level_r;
            fall_det_s = ~sync_last_s & level_r;
        end else begin
            rise_det_s = 1'b0;
            fall_det_s = 1'b0;
        end
    end
`else
    logic dly_r;

    // Delay flop holding the previous synchronized level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_r <= 1'b0;
        end else begin
            dly_r <= sync_last_s;
        end
    end

    // Every synchronized transition is an edge.
    always_comb begin
        rise_det_s = sync_last_s & ~dly_r;
        fall_det_s = ~sync_last_s & dly_r;
    end
`endif

    // Registered single-cycle strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_pulse_r <= 1'b0;
            fall_pulse_r <= 1'b0;
        end else begin
            rise_pulse_r <= rise_det_s;
            fall_pulse_r <= fall_det_s;
        end
    end

    assign rise_next  = rise_det_s;
    assign fall_next  = fall_det_s;
    assign rise_pulse = rise_pulse_r;
    assign fall_pulse = fall_pulse_r;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous signal in clk cycles.
// Lock is gained on the second rise after idle and dropped when no rise is
// seen for TIMEOUT cycles. A rise landing on the timeout cycle keeps lock.
// Optional macro CLK_PERIOD_METER_GLITCH_FILTER_EN enables the 2-cycle
// input filter inside sync_edge_det.
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_n,
    clk_period_meter_if.slave   mif
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    // The count reaches TIMEOUT on the edge where it moves on from TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_PRE_TIMEOUT = CNT_W'(TIMEOUT - 1);

    logic             rise_s;
    logic             fall_s;
    logic             rise_pulse_s;
    logic             fall_pulse_s;
    logic             measuring_s;
    logic             timeout_hit_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    meter_state_e     state_r;
    meter_state_e     state_nxt_s;
    logic             meas_valid_r;
    logic             meas_valid_nxt_s;
    logic             locked_r;
    logic             locked_nxt_s;
    logic             timeout_r;
    logic             timeout_nxt_s;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] period_nxt_s;
    logic [CNT_W-1:0] high_time_r;
    logic [CNT_W-1:0] high_time_nxt_s;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (mif.sig_in),
        .rise_next  (rise_s),
        .fall_next  (fall_s),
        .rise_pulse (rise_pulse_s),
        .fall_pulse (fall_pulse_s)
    );

    // Saturating increment and timeout detection derived from the counter.
    always_comb begin
        if (cnt_r == CNT_MAX) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + CNT_ONE;
        end
        timeout_hit_s = (cnt_r == CNT_PRE_TIMEOUT);
        measuring_s   = is_measuring(state_r);
    end

    // Cycle counter: restarts on each rise, otherwise counts up and saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (rise_s) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_inc_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; a rise always takes priority over a timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_nxt_s = ARM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ARM: begin
                if (rise_s) begin
                    state_nxt_s = LOCKED;
                end else if (timeout_hit_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ARM;
                end
            end
            LOCKED: begin
                if (rise_s) begin
                    state_nxt_s = LOCKED;
                end else if (timeout_hit_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM output logic: next values of the registered measurement outputs.
    always_comb begin
        meas_valid_nxt_s = 1'b0;
        timeout_nxt_s    = 1'b0;
        period_nxt_s     = period_r;
        high_time_nxt_s  = high_time_r;
        locked_nxt_s     = (state_nxt_s == LOCKED);
        if (rise_s && measuring_s) begin
            meas_valid_nxt_s = 1'b1;
            period_nxt_s     = cnt_inc_s;
        end else begin
            meas_valid_nxt_s = 1'b0;
            period_nxt_s     = period_r;
        end
        if (fall_s && measuring_s) begin
            high_time_nxt_s = cnt_inc_s;
        end else begin
            high_time_nxt_s = high_time_r;
        end
        if ((state_r == LOCKED) && !rise_s && timeout_hit_s) begin
            timeout_nxt_s = 1'b1;
        end else begin
            timeout_nxt_s = 1'b0;
        end
    end

    // Output registers; measurements survive a timeout and clear only on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_valid_r <= 1'b0;
            locked_r     <= 1'b0;
            timeout_r    <= 1'b0;
            period_r     <= CNT_ZERO;
            high_time_r  <= CNT_ZERO;
        end else begin
            meas_valid_r <= meas_valid_nxt_s;
            locked_r     <= locked_nxt_s;
            timeout_r    <= timeout_nxt_s;
            period_r     <= period_nxt_s;
            high_time_r  <= high_time_nxt_s;
        end
    end

    assign mif.rise_pulse = rise_pulse_s;
    assign mif.fall_pulse = fall_pulse_s;
    assign mif.meas_valid = meas_valid_r;
    assign mif.locked     = locked_r;
    assign mif.timeout    = timeout_r;
    assign mif.period     = period_r;
    assign mif.high_time  = high_time_r;

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter with a timestamp-based reference
// model: edges are predicted from the history of driven levels, and period,
// high time and timeout are computed as differences of edge timestamps.
module tb_clk_period_meter;

    localparam int S  = 2;
    localparam int CW = 16;
    localparam int TO = 64;

    logic clk;
    logic rst_n;

    clk_period_meter_if #(.CNT_W(CW)) mif ();

    clk_period_meter #(
        .SYNC_STAGES (S),
        .CNT_W       (CW),
        .TIMEOUT     (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mif   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model state.
    logic          acc_h [0:S+1];
    logic          prev_lvl;
    int            cyc;
    int            last_rise;
    int            mode;            // 0 idle, 1 one rise seen, 2 locked
    logic          exp_rise, exp_fall, exp_mv, exp_to, exp_locked;
    logic [CW-1:0] exp_period, exp_high;

    function automatic logic [4:0] dut_flags();
        return {mif.rise_pulse, mif.fall_pulse, mif.meas_valid, mif.timeout, mif.locked};
    endfunction

    function automatic logic [4:0] exp_flags();
        return {exp_rise, exp_fall, exp_mv, exp_to, exp_locked};
    endfunction

    task automatic model_reset();
        for (int i = 0; i <= S + 1; i++) acc_h[i] = 1'b0;
        prev_lvl   = 1'b0;
        cyc        = 0;
        last_rise  = 0;
        mode       = 0;
        exp_rise   = 1'b0;
        exp_fall   = 1'b0;
        exp_mv     = 1'b0;
        exp_to     = 1'b0;
        exp_locked = 1'b0;
        exp_period = '0;
        exp_high   = '0;
    endtask

    // One clock edge of the model; v is the level sampled at that edge.
    task automatic model_update(input logic v);
        logic a, r, f;
        a = v;
`ifdef CLK_PERIOD_METER_GLITCH_FILTER_EN
        if (v != prev_lvl) a = acc_h[0];
        prev_lvl = v;
`endif
        for (int i = S + 1; i > 0; i--) acc_h[i] = acc_h[i-1];
        acc_h[0] = a;
        cyc++;
        r = acc_h[S] & ~acc_h[S+1];
        f = ~acc_h[S] & acc_h[S+1];
        exp_rise = r;
        exp_fall = f;
        exp_mv   = 1'b0;
        exp_to   = 1'b0;
        if (f && mode > 0) exp_high = CW'(cyc - last_rise);
        if (r) begin
            if (mode > 0) begin
                exp_period = CW'(cyc - last_rise);
                exp_mv     = 1'b1;
                mode       = 2;
            end else begin
                mode = 1;
            end
            last_rise = cyc;
        end else if (mode > 0 && (cyc - last_rise) == TO) begin
            if (mode == 2) exp_to = 1'b1;
            mode = 0;
        end
        exp_locked = (mode == 2);
    endtask

    // Drive one level for one cycle; returns 1 time unit after the edge.
    task automatic step(input logic v);
        mif.sig_in = v;
        @(posedge clk);
        model_update(v);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        if (dut_flags() !== 5'b0) begin
            fails++; $display("FAIL reset_flags got=%b exp=%b", dut_flags(), 5'b0);
        end else passes++;
        checks++;
        if ({mif.period, mif.high_time} !== {CW{2'b00}}) begin
            fails++; $display("FAIL reset_meas got=%0d/%0d exp=0/0", mif.period, mif.high_time);
        end else passes++;
        checks++;
        model_reset();
        rst_n = 1'b1;
    endtask

    // Square wave as from a divider toggling every 'half' cycles.
    task automatic test_divider(input int half, input int n_per, input string nm);
        int mv_last, mv_prev;
        mv_last = -1;
        mv_prev = -1;
        for (int p = 0; p < n_per; p++) begin
            for (int i = 0; i < 2 * half; i++) begin
                step(i < half);
                if (dut_flags() !== exp_flags()) begin
                    fails++; $display("FAIL %s_flags cyc=%0d got=%b exp=%b", nm, cyc, dut_flags(), exp_flags());
                end else passes++;
                checks++;
                if ({mif.period, mif.high_time} !== {exp_period, exp_high}) begin
                    fails++; $display("FAIL %s_meas cyc=%0d got=%0d/%0d exp=%0d/%0d", nm, cyc, mif.period, mif.high_time, exp_period, exp_high);
                end else passes++;
                checks++;
                if (mif.meas_valid === 1'b1) begin
                    mv_prev = mv_last;
                    mv_last = cyc;
                end
            end
        end
        if (mv_last - mv_prev !== 2 * half) begin
            fails++; $display("FAIL %s_mv_spacing got=%0d exp=%0d", nm, mv_last - mv_prev, 2 * half);
        end else passes++;
        checks++;
        if (mif.period !== CW'(2 * half)) begin
            fails++; $display("FAIL %s_period got=%0d exp=%0d", nm, mif.period, 2 * half);
        end else passes++;
        checks++;
        if (mif.high_time !== CW'(half)) begin
            fails++; $display("FAIL %s_high got=%0d exp=%0d", nm, mif.high_time, half);
        end else passes++;
        checks++;
        if (mif.locked !== 1'b1) begin
            fails++; $display("FAIL %s_locked got=%b exp=1", nm, mif.locked);
        end else passes++;
        checks++;
    endtask

    // Hold high after lock: one timeout, period retained, next rise unmeasured.
    task automatic test_timeout();
        int n_to, n_mv;
        logic v;
        n_to = 0;
        n_mv = 0;
        for (int i = 0; i < 30 + 90 + 20; i++) begin
            if (i < 30)       v = ((i % 10) < 5);
            else if (i < 120) v = 1'b1;
            else              v = (i >= 130 && i < 135);
            step(v);
            if (dut_flags() !== exp_flags()) begin
                fails++; $display("FAIL timeout_flags cyc=%0d got=%b exp=%b", cyc, dut_flags(), exp_flags());
            end else passes++;
            checks++;
            if ({mif.period, mif.high_time} !== {exp_period, exp_high}) begin
                fails++; $display("FAIL timeout_meas cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, mif.period, mif.high_time, exp_period, exp_high);
            end else passes++;
            checks++;
            if (i >= 30 && mif.timeout === 1'b1) n_to++;
            if (i >= 120 && mif.meas_valid === 1'b1) n_mv++;
            if (i == 119) begin
                if (mif.period !== CW'(10) || mif.locked !== 1'b0) begin
                    fails++; $display("FAIL timeout_hold got=%0d/%b exp=10/0", mif.period, mif.locked);
                end else passes++;
                checks++;
            end
        end
        if (n_to !== 1) begin
            fails++; $display("FAIL timeout_count got=%0d exp=1", n_to);
        end else passes++;
        checks++;
        if (n_mv !== 0) begin
            fails++; $display("FAIL timeout_relock_mv got=%0d exp=0", n_mv);
        end else passes++;
        checks++;
    endtask

    // Period exactly TO: every rise lands on the timeout cycle and must win.
    task automatic test_rise_at_timeout();
        int n_to;
        n_to = 0;
        for (int i = 0; i < 4 * TO; i++) begin
            step((i % TO) < (TO / 2));
            if (dut_flags() !== exp_flags()) begin
                fails++; $display("FAIL rise_at_to_flags cyc=%0d got=%b exp=%b", cyc, dut_flags(), exp_flags());
            end else passes++;
            checks++;
            if ({mif.period, mif.high_time} !== {exp_period, exp_high}) begin
                fails++; $display("FAIL rise_at_to_meas cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, mif.period, mif.high_time, exp_period, exp_high);
            end else passes++;
            checks++;
            if (mif.timeout === 1'b1) n_to++;
        end
        if (n_to !== 0) begin
            fails++; $display("FAIL rise_at_to_count got=%0d exp=0", n_to);
        end else passes++;
        checks++;
        if (mif.period !== CW'(TO) || mif.locked !== 1'b1) begin
            fails++; $display("FAIL rise_at_to_lock got=%0d/%b exp=%0d/1", mif.period, mif.locked, TO);
        end else passes++;
        checks++;
    endtask

    // Asynchronous reset mid-period, then re-acquire from scratch.
    task automatic test_async_reset();
        int n_rise, rises_at_mv;
        for (int i = 0; i < 27; i++) step((i % 10) < 5);
        #2;
        rst_n = 1'b0;
        #1;
        if (dut_flags() !== 5'b0 || {mif.period, mif.high_time} !== {CW{2'b00}}) begin
            fails++; $display("FAIL async_reset got=%b %0d/%0d exp=00000 0/0", dut_flags(), mif.period, mif.high_time);
        end else passes++;
        checks++;
        model_reset();
        mif.sig_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_rise = 0;
        rises_at_mv = -1;
        for (int i = 0; i < 40; i++) begin
            step((i % 10) >= 5);
            if (dut_flags() !== exp_flags()) begin
                fails++; $display("FAIL arst_flags cyc=%0d got=%b exp=%b", cyc, dut_flags(), exp_flags());
            end else passes++;
            checks++;
            if (mif.rise_pulse === 1'b1) n_rise++;
            if (mif.meas_valid === 1'b1 && rises_at_mv < 0) rises_at_mv = n_rise;
        end
        if (rises_at_mv !== 2) begin
            fails++; $display("FAIL arst_first_mv got=%0d exp=2", rises_at_mv);
        end else passes++;
        checks++;
        for (int i = 0; i < 10; i++) step(1'b0);
    endtask

    // Single-cycle high glitch.
    task automatic test_glitch();
        int n_rise, n_fall, rc, fc;
        n_rise = 0;
        n_fall = 0;
        rc = 0;
        fc = 0;
        for (int i = 0; i < 16; i++) begin
            step(i == 5);
            if (dut_flags() !== exp_flags()) begin
                fails++; $display("FAIL glitch_flags cyc=%0d got=%b exp=%b", cyc, dut_flags(), exp_flags());
            end else passes++;
            checks++;
            if (mif.rise_pulse === 1'b1) begin n_rise++; rc = cyc; end
            if (mif.fall_pulse === 1'b1) begin n_fall++; fc = cyc; end
        end
`ifdef CLK_PERIOD_METER_GLITCH_FILTER_EN
        if (n_rise !== 0 || n_fall !== 0) begin
            fails++; $display("FAIL glitch_strobes got=%0d/%0d exp=0/0", n_rise, n_fall);
        end else passes++;
        checks++;
`else
        if (n_rise !== 1 || n_fall !== 1 || (fc - rc) !== 1) begin
            fails++; $display("FAIL glitch_strobes got=%0d/%0d gap=%0d exp=1/1 gap=1", n_rise, n_fall, fc - rc);
        end else passes++;
        checks++;
`endif
    endtask

    // Random level widths, with occasional long gaps that force timeouts.
    task automatic test_random();
        logic v;
        int w;
        v = 1'b0;
        for (int s = 0; s < 60; s++) begin
            v = ~v;
            w = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 80) : $urandom_range(1, 14);
            for (int i = 0; i < w; i++) begin
                step(v);
                if (dut_flags() !== exp_flags()) begin
                    fails++; $display("FAIL random_flags cyc=%0d got=%b exp=%b", cyc, dut_flags(), exp_flags());
                end else passes++;
                checks++;
                if ({mif.period, mif.high_time} !== {exp_period, exp_high}) begin
                    fails++; $display("FAIL random_meas cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, mif.period, mif.high_time, exp_period, exp_high);
                end else passes++;
                checks++;
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        mif.sig_in = 1'b0;
        model_reset();
        test_reset();
        test_divider(2, 4, "div1");
        test_divider(5, 5, "div4");
        test_timeout();
        test_rise_at_timeout();
        test_async_reset();
        test_glitch();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
